// File: rtl/riscv_core_dpath_vec_mem_seq_if.sv
// Bus bundle for the vector memory element sequencer.
//   req_*     : vector command from the register-file / ALU stage
//   memreq_*  : per-element request to the data memory port
//   memresp_* : in-order memory responses (always accepted)
//   resp_*    : packed vector result / completion back to writeback
// slave is the sequencer's view; master is the surrounding system's view.
interface riscv_core_dpath_vec_mem_seq_if #(
  parameter int unsigned NLANES = 8,
  parameter int unsigned EW     = 32,
  parameter int unsigned AW     = 32
);
  logic                   req_val;
  logic                   req_rdy;
  logic                   req_rw;
  logic [AW-1:0]          req_base;
  logic [AW-1:0]          req_stride;
  logic [3:0]             req_vl;
  logic [NLANES-1:0]      req_vm;
  logic [NLANES*EW-1:0]   req_data;

  logic                   memreq_val;
  logic                   memreq_rdy;
  logic                   memreq_rw;
  logic [AW-1:0]          memreq_addr;
  logic [EW-1:0]          memreq_data;

  logic                   memresp_val;
  logic [EW-1:0]          memresp_data;

  logic                   resp_val;
  logic                   resp_rdy;
  logic [NLANES*EW-1:0]   resp_data;

  modport slave (
    input  req_val, req_rw, req_base, req_stride, req_vl, req_vm, req_data,
    output req_rdy,
    output memreq_val, memreq_rw, memreq_addr, memreq_data,
    input  memreq_rdy,
    input  memresp_val, memresp_data,
    output resp_val, resp_data,
    input  resp_rdy
  );

  modport master (
    output req_val, req_rw, req_base, req_stride, req_vl, req_vm, req_data,
    input  req_rdy,
    input  memreq_val, memreq_rw, memreq_addr, memreq_data,
    output memreq_rdy,
    output memresp_val, memresp_data,
    input  resp_val, resp_data,
    output resp_rdy
  );
endinterface

// File: rtl/riscv_core_dpath_vec_mem_seq.sv
// Vector load/store element sequencer.
// Takes one masked, length-limited vector memory command, issues one EW-bit memory request
// per active element (lowest index first, inactive elements skipped), and collects in-order
// responses. Loads pack response data into resp_data; stores report completion with
// resp_data = 0.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   bus        : slave modport carrying the req_*, memreq_*, memresp_* and resp_* signals
module riscv_core_dpath_vec_mem_seq #(
  parameter int unsigned NLANES = 8,
  parameter int unsigned EW     = 32,
  parameter int unsigned AW     = 32
) (
  input logic                            clk,
  input logic                            reset,
  riscv_core_dpath_vec_mem_seq_if.slave  bus
);

  localparam int unsigned IW = (NLANES > 1) ? $clog2(NLANES) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e                 state_q, state_d;
  logic                   rw_q;
  logic [AW-1:0]          base_q, stride_q;
  logic [NLANES*EW-1:0]   data_q;
  logic [NLANES*EW-1:0]   result_q, result_d;
  // Remaining-work masks: the lowest set bit is the issue / response pointer, and the
  // popcount of resp_mask_q is the number of responses still owed.
  logic [NLANES-1:0]      issue_mask_q, issue_mask_d;
  logic [NLANES-1:0]      resp_mask_q, resp_mask_d;

  logic [3:0]             vl_eff;
  logic [NLANES-1:0]      active_mask;
  logic [IW-1:0]          issue_idx, resp_idx;
  logic                   capture, req_fire, resp_fire;

  function automatic logic [IW-1:0] lowest_set(input logic [NLANES-1:0] m);
    logic [IW-1:0] idx;
    idx = '0;
    for (int i = NLANES - 1; i >= 0; i--) begin
      if (m[i]) idx = IW'(i);
    end
    return idx;
  endfunction

  always_comb begin
    vl_eff = (bus.req_vl > 4'(NLANES)) ? 4'(NLANES) : bus.req_vl;
    for (int i = 0; i < NLANES; i++) begin
      active_mask[i] = bus.req_vm[i] && (i < int'(vl_eff));
    end
  end

  assign issue_idx = lowest_set(issue_mask_q);
  assign resp_idx  = lowest_set(resp_mask_q);

  // Outputs
  assign bus.req_rdy     = (state_q == StIdle) && !reset;
  assign bus.memreq_val  = (state_q == StIssue);
  assign bus.memreq_rw   = bus.memreq_val && rw_q;
  assign bus.memreq_addr = bus.memreq_val ? (base_q + AW'(issue_idx) * stride_q) : '0;
  assign bus.memreq_data = (bus.memreq_val && rw_q) ? data_q[32'(issue_idx) * EW +: EW] : '0;
  assign bus.resp_val    = (state_q == StDone);
  assign bus.resp_data   = result_q;

  assign capture   = (state_q == StIdle) && bus.req_val && !reset;
  assign req_fire  = bus.memreq_val && bus.memreq_rdy;
  // Responses only count while a command is in flight; strays in IDLE/DONE are dropped.
  assign resp_fire = bus.memresp_val && (resp_mask_q != '0) &&
                     ((state_q == StIssue) || (state_q == StDrain));

  always_comb begin
    state_d      = state_q;
    issue_mask_d = issue_mask_q;
    resp_mask_d  = resp_mask_q;
    result_d     = result_q;

    if (resp_fire) begin
      resp_mask_d[resp_idx] = 1'b0;
      if (!rw_q) result_d[32'(resp_idx) * EW +: EW] = bus.memresp_data;
    end
    if (req_fire) begin
      issue_mask_d[issue_idx] = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (capture) begin
          issue_mask_d = active_mask;
          resp_mask_d  = active_mask;
          result_d     = '0;
          state_d      = (active_mask != '0) ? StIssue : StDone;
        end
      end
      StIssue: begin
        // A same-cycle response to the final request can close the command immediately.
        if (req_fire && (issue_mask_d == '0)) begin
          state_d = (resp_mask_d == '0) ? StDone : StDrain;
        end
      end
      StDrain: begin
        if (resp_mask_d == '0) state_d = StDone;
      end
      StDone: begin
        if (bus.resp_rdy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      rw_q         <= 1'b0;
      base_q       <= '0;
      stride_q     <= '0;
      data_q       <= '0;
      result_q     <= '0;
      issue_mask_q <= '0;
      resp_mask_q  <= '0;
    end else begin
      state_q      <= state_d;
      result_q     <= result_d;
      issue_mask_q <= issue_mask_d;
      resp_mask_q  <= resp_mask_d;
      if (capture) begin
        rw_q     <= bus.req_rw;
        base_q   <= bus.req_base;
        stride_q <= bus.req_stride;
        data_q   <= bus.req_data;
      end
    end
  end

endmodule

// File: doc/riscv_core_dpath_vec_mem_seq.md
Name: riscv_core_dpath_vec_mem_seq

Overview:
- Vector load/store element sequencer: the memory-side counterpart to the 8-lane x 32-bit vector ALU datapath.
- Accepts one masked, length-limited vector memory command. Loads: issues one 32-bit memory request per active element and packs the responses into a 256-bit vector for register writeback. Stores: unpacks a 256-bit vector into per-element 32-bit writes.
- Sits between the vector register file / ALU stage and the data memory port.

Parameters:
NLANES, 8, number of 32-bit elements per vector
EW, 32, element width in bits
AW, 32, address width

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
req_val  input  1  command valid
req_rdy  output  1  command ready; high only in IDLE
req_rw  input  1  0 = load, 1 = store
req_base  input  AW  element-0 byte address
req_stride  input  AW  byte stride between elements (two's complement)
req_vl  input  4  vector length, 0..8
req_vm  input  NLANES  per-element mask; bit i enables element i
req_data  input  NLANES*EW  store data; element i in bits [32i+31:32i]
memreq_val  output  1  memory request valid
memreq_rdy  input  1  memory ready
memreq_rw  output  1  0 = read, 1 = write
memreq_addr  output  AW  element byte address
memreq_data  output  EW  write data (0 for reads)
memresp_val  input  1  memory response valid; always accepted; responses return in request order
memresp_data  input  EW  read data (ignored for writes)
resp_val  output  1  vector result/completion valid
resp_rdy  input  1  consumer ready
resp_data  output  NLANES*EW  load result (0 for stores)

Behaviour:
- Command capture: on req_val && req_rdy, latch rw, base, stride, mask, data.
  - Effective vl = min(req_vl, 8).
  - Active set A = {i : i < vl && vm[i]}; all other elements are inactive.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE -> ISSUE on capture when A is non-empty; IDLE -> DONE when A is empty (vl = 0 or mask all zero).
  - ISSUE: memreq_val = 1, driving the lowest active element i not yet issued.
    - memreq_addr = base + i*stride, modulo 2^AW (wraps, no fault).
    - memreq_data = element i for stores, 0 for loads.
    - On memreq_rdy the request is accepted and the issue pointer advances to the next active element (inactive elements are skipped, no bubble).
    - When the last active element is accepted: go to DRAIN, or straight to DONE if its response arrives in that same cycle and completes the count.
  - DRAIN: memreq_val = 0; wait until the response count equals |A|, then go to DONE.
  - DONE: resp_val = 1; on resp_rdy go to IDLE. resp_data stays stable while resp_val && !resp_rdy.
- Responses: multiple requests may be outstanding.
  - A separate response pointer walks the active elements in ascending order.
  - For loads, memresp_data is written into the pointed lane.
  - A response may arrive in the same cycle as a request is accepted; both pointers update independently.
- Load result: inactive lanes read 0. The result register is cleared on each command capture.
- Store result: resp_data = 0. resp_val signals that all write acknowledgements have been received.
- Throughput: one request per cycle while memreq_rdy stays high. Minimum latency from capture to resp_val is |A| + 1 cycles with zero-latency responses.
- memreq_val must not drop before acceptance, and memreq_addr/memreq_data must stay stable while memreq_val && !memreq_rdy.
- Reset, including mid-operation:
  - State returns to IDLE and both pointers and the response count clear.
  - Outputs: req_rdy = 1 in the cycle after reset deasserts (0 while reset is high); memreq_val = 0, resp_val = 0, resp_data = 0, memreq_addr = 0, memreq_data = 0.
  - Responses still in flight from an aborted command are the memory's responsibility and are not tracked.
- Stray memresp_val in IDLE or DONE is ignored.

Test Plan:
- Load, vl=8, vm=0xFF, base=0x1000, stride=4, memory returns addr>>2 -> requests at 0x1000..0x101C on consecutive cycles; resp_data lanes = 0x400..0x407; resp_val 9 cycles after capture.
- Masked store, vl=5, vm=0xA5, stride=-8 (0xFFFFFFF8), base=0x20 -> writes only elements 0 and 2 at 0x20 and 0x10; element 5 (vl-excluded) and element 7 never issued; resp_data=0.
- Empty command: vl=0, or vl=8 with vm=0x00 -> no memreq_val; resp_val in the cycle after capture with resp_data=0.
- Backpressure: memreq_rdy toggles 1,0,0,1 and response latency is 3 cycles -> addr/data held stable while stalled; no duplicate or skipped element; lanes correct.
- Wrap and clamp: base=0xFFFFFFFC, stride=4, req_vl=12 -> treated as vl=8; element 1 address = 0x00000000.
- Reset asserted in DRAIN with 2 responses outstanding, then resp_rdy held low in a later DONE -> after reset: IDLE with all outputs 0 and req_rdy=1; in the later DONE, resp_data stays stable until resp_rdy.
